// File: rtl/trace_frame_collector_if.sv
// Trace chunk input, frame read-out handshake and status bundle for trace_frame_collector.
interface trace_frame_collector_if #(
    parameter int MAX_BUS_WIDTH = 4
);
    logic [1:0]               width;
    logic                     trace_valid;
    logic [MAX_BUS_WIDTH-1:0] trace_data;
    logic                     sync;
    logic                     frame_avail;
    logic [15:0]              frame_word;
    logic                     frame_word_next;
    logic                     frame_next;
    logic [7:0]               ovf_count;

    modport master (
        output width, trace_valid, trace_data, frame_word_next, frame_next,
        input  sync, frame_avail, frame_word, ovf_count
    );

    modport slave (
        input  width, trace_valid, trace_data, frame_word_next, frame_next,
        output sync, frame_avail, frame_word, ovf_count
    );
endinterface

// File: rtl/trace_frame_collector.sv
// TPIU trace frame collector: aligns 1/2/4-bit chunks on full sync, assembles 16-byte frames
// as eight 16-bit words, drops idle frames and buffers FRAME_DEPTH frames for word-serial readout.
module trace_frame_collector #(
    parameter int MAX_BUS_WIDTH = 4,
    parameter int FRAME_DEPTH   = 4,
    parameter int SYNC_TIMEOUT  = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    trace_frame_collector_if.slave bus
);
    localparam int              PTR_W     = $clog2(FRAME_DEPTH);
    localparam int              TO_W      = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT + 1) : 1;
    localparam logic [PTR_W:0]  OCC_FULL  = FRAME_DEPTH[PTR_W:0];
    localparam logic [TO_W:0]   TO_LIM    = SYNC_TIMEOUT[TO_W:0];
    localparam logic [31:0]     SYNC_WORD = 32'h7FFF_FFFF;
    localparam logic [15:0]     IDLE_WORD = 16'h7FFF;

    logic [MAX_BUS_WIDTH-1:0] raw_s;
    logic [3:0]               chunk_s;
    logic [4:0]               bit_sum_s;
    logic [31:0]              win_next_s;
    logic [15:0]              word_next_s;
    logic                     width_chg_s;
    logic                     sync_hit_s;
    logic                     word_done_s;
    logic                     frame_done_s;
    logic                     word_idle_s;
    logic                     to_expire_s;
    logic                     pop_s;
    logic                     adv_s;
    logic                     full_s;
    logic                     commit_s;
    logic                     drop_s;
    logic [PTR_W:0]           occ_next_s;

    logic [31:0]              win_r;
    logic [15:0]              word_r;
    logic [3:0]               bit_cnt_r;
    logic [2:0]               wr_word_r;
    logic [1:0]               width_q_r;
    logic                     sync_r;
    logic                     idle_r;
    logic                     pending_r;
    logic [TO_W-1:0]          to_cnt_r;
    logic [7:0][15:0]         stage_r;
    logic [7:0][15:0]         buf_r [FRAME_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_r;
    logic [PTR_W-1:0]         rd_ptr_r;
    logic [2:0]               rd_word_r;
    logic [PTR_W:0]           occ_r;
    logic                     frame_avail_r;
    logic [7:0]               ovf_r;

    assign raw_s   = bus.trace_data;
    assign chunk_s = 4'(raw_s);

    // Chunk shift (newest bits enter at the top), sync match and word/frame completion
    always_comb begin
        bit_sum_s   = 5'd0;
        win_next_s  = win_r;
        word_next_s = word_r;
        case (bus.width)
            2'b10: begin
                bit_sum_s   = {1'b0, bit_cnt_r} + 5'd2;
                win_next_s  = {chunk_s[1:0], win_r[31:2]};
                word_next_s = {chunk_s[1:0], word_r[15:2]};
            end
            2'b11: begin
                bit_sum_s   = {1'b0, bit_cnt_r} + 5'd4;
                win_next_s  = {chunk_s, win_r[31:4]};
                word_next_s = {chunk_s, word_r[15:4]};
            end
            default: begin
                bit_sum_s   = {1'b0, bit_cnt_r} + 5'd1;
                win_next_s  = {chunk_s[0], win_r[31:1]};
                word_next_s = {chunk_s[0], word_r[15:1]};
            end
        endcase
        width_chg_s  = (bus.width != width_q_r);
        sync_hit_s   = bus.trace_valid && !width_chg_s && (win_next_s == SYNC_WORD);
        word_done_s  = bus.trace_valid && !width_chg_s && sync_r && !sync_hit_s &&
                       (bit_sum_s == 5'd16);
        frame_done_s = word_done_s && (wr_word_r == 3'd7);
        word_idle_s  = (word_next_s == IDLE_WORD);
        to_expire_s  = frame_done_s && (SYNC_TIMEOUT > 32'sd0) &&
                       (({1'b0, to_cnt_r} + (TO_W + 1)'(1'b1)) == TO_LIM);
    end

    // Read-side handshake: a pop in the commit cycle frees the slot the incoming frame needs
    always_comb begin
        pop_s      = bus.frame_next && frame_avail_r;
        adv_s      = bus.frame_word_next && frame_avail_r && !bus.frame_next;
        full_s     = (occ_r == OCC_FULL);
        commit_s   = pending_r && (!full_s || pop_s);
        drop_s     = pending_r && full_s && !pop_s;
        occ_next_s = occ_r;
        case ({commit_s, pop_s})
            2'b10:   occ_next_s = occ_r + (PTR_W + 1)'(1'b1);
            2'b01:   occ_next_s = occ_r - (PTR_W + 1)'(1'b1);
            default: occ_next_s = occ_r;
        endcase
    end

    // Sync search/loss and word assembly into the staging frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_r     <= 32'h0000_0000;
            word_r    <= 16'h0000;
            bit_cnt_r <= 4'd0;
            wr_word_r <= 3'd0;
            width_q_r <= 2'b00;
            sync_r    <= 1'b0;
            idle_r    <= 1'b0;
            pending_r <= 1'b0;
            to_cnt_r  <= {TO_W{1'b0}};
            stage_r   <= {128{1'b0}};
        end else begin
            width_q_r <= bus.width;
            // Completed frame is handed to the buffer on the next edge unless it was all idle
            pending_r <= frame_done_s && !(idle_r && word_idle_s);
            if (width_chg_s) begin
                sync_r    <= 1'b0;
                win_r     <= 32'h0000_0000;
                bit_cnt_r <= 4'd0;
                wr_word_r <= 3'd0;
            end else if (bus.trace_valid) begin
                win_r <= win_next_s;
                if (sync_hit_s) begin
                    sync_r    <= 1'b1;
                    to_cnt_r  <= {TO_W{1'b0}};
                    bit_cnt_r <= 4'd0;
                    wr_word_r <= 3'd0;
                end else if (sync_r) begin
                    word_r    <= word_next_s;
                    bit_cnt_r <= bit_sum_s[3:0];
                    if (word_done_s) begin
                        stage_r[wr_word_r] <= word_next_s;
                        wr_word_r          <= wr_word_r + 3'd1;
                        idle_r             <= ((wr_word_r == 3'd0) || idle_r) && word_idle_s;
                        if (frame_done_s) begin
                            to_cnt_r <= to_cnt_r + TO_W'(1'b1);
                            if (to_expire_s) begin
                                sync_r <= 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Buffer pointers, occupancy, read word index and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            rd_word_r     <= 3'd0;
            occ_r         <= {(PTR_W + 1){1'b0}};
            frame_avail_r <= 1'b0;
            ovf_r         <= 8'd0;
        end else begin
            occ_r         <= occ_next_s;
            frame_avail_r <= (occ_next_s != {(PTR_W + 1){1'b0}});
            if (commit_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r  <= rd_ptr_r + PTR_W'(1'b1);
                rd_word_r <= 3'd0;
            end else if (adv_s && (rd_word_r != 3'd7)) begin
                rd_word_r <= rd_word_r + 3'd1;
            end
            if (drop_s && (ovf_r != 8'hFF)) begin
                ovf_r <= ovf_r + 8'd1;
            end
        end
    end

    // Frame storage; contents are only observable once frame_avail is set
    always_ff @(posedge clk) begin
        if (commit_s) begin
            buf_r[wr_ptr_r] <= stage_r;
        end
    end

    assign bus.sync        = sync_r;
    assign bus.frame_avail = frame_avail_r;
    assign bus.ovf_count   = ovf_r;
    assign bus.frame_word  = frame_avail_r ? buf_r[rd_ptr_r][rd_word_r] : 16'h0000;
endmodule

// File: tb/tb_trace_frame_collector.sv
// Directed sequence with randomized frame data and widths, checked against a frame-level
// model: expected words come from byte pairs, buffering/overflow/timeout from queue rules.
module tb_trace_frame_collector;
    localparam int DEPTH = 4;
    localparam int TMO   = 4;

    typedef logic [7:0][15:0] frame_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    trace_frame_collector_if #(.MAX_BUS_WIDTH(4)) bus ();

    trace_frame_collector #(
        .MAX_BUS_WIDTH(4),
        .FRAME_DEPTH  (DEPTH),
        .SYNC_TIMEOUT (TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         passed = 0;
    frame_t     exp_q[$];
    bit         m_sync;
    int         m_to;
    int         m_ovf;
    logic [7:0] bytes [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_bytes();
        for (int b = 0; b < 16; b++) bytes[b] = 8'($urandom_range(0, 255));
    endtask

    task automatic set_width(input logic [1:0] w);
        if (bus.width != w) begin
            bus.trace_valid = 1'b0;
            bus.width       = w;
            tick();
            m_sync = 1'b0;
            chk("sync_wchg", 32'(bus.sync), 32'(m_sync));
        end
    endtask

    // Streams optional sync then nbytes of data LSB first; unused upper chunk bits are junk
    task automatic send_raw(input bit with_sync, input int nbytes);
        bit         q[$];
        int         n;
        logic [3:0] d;
        if (with_sync) for (int i = 0; i < 32; i++) q.push_back(i < 31);
        for (int b = 0; b < nbytes; b++)
            for (int i = 0; i < 8; i++) q.push_back(bytes[b][i]);
        n = (bus.width == 2'b11) ? 4 : ((bus.width == 2'b10) ? 2 : 1);
        while (q.size() > 0) begin
            d = 4'($urandom);
            for (int k = 0; k < n; k++) d[k] = q.pop_front();
            bus.trace_valid = 1'b1;
            bus.trace_data  = d;
            tick();
        end
        bus.trace_valid = 1'b0;
        bus.trace_data  = 4'b0000;
    endtask

    task automatic send_frame(input bit with_sync, input bit pop_now);
        frame_t f;
        bit     idle;
        bit     keep;
        idle = 1'b1;
        for (int k = 0; k < 8; k++) begin
            f[k] = {bytes[2*k+1], bytes[2*k]};
            if (f[k] != 16'h7FFF) idle = 1'b0;
        end
        send_raw(with_sync, 16);
        if (with_sync) begin
            m_sync = 1'b1;
            m_to   = 0;
        end
        keep = m_sync && !idle;
        if (m_sync) begin
            m_to++;
            if (m_to == TMO) m_sync = 1'b0;
        end
        chk("sync_frame", 32'(bus.sync), 32'(m_sync));
        chk("avail_pre", 32'(bus.frame_avail), 32'(exp_q.size() != 0));
        bus.frame_next = pop_now;
        tick();
        bus.frame_next = 1'b0;
        if (pop_now && exp_q.size() != 0) exp_q.delete(0);
        if (keep) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(f);
            else if (m_ovf < 255) m_ovf++;
        end
        chk("avail_post", 32'(bus.frame_avail), 32'(exp_q.size() != 0));
        chk("ovf", 32'(bus.ovf_count), 32'(m_ovf));
    endtask

    task automatic read_frame();
        frame_t f;
        chk("avail_rd", 32'(bus.frame_avail), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            f = exp_q.pop_front();
            for (int w = 0; w < 8; w++) begin
                chk($sformatf("word%0d", w), 32'(bus.frame_word), 32'(f[w]));
                bus.frame_word_next = 1'b1;
                tick();
                bus.frame_word_next = 1'b0;
            end
            chk("word_sat", 32'(bus.frame_word), 32'(f[7]));
            // frame_next must win over a simultaneous frame_word_next
            bus.frame_next      = 1'b1;
            bus.frame_word_next = 1'b1;
            tick();
            bus.frame_next      = 1'b0;
            bus.frame_word_next = 1'b0;
            chk("avail_pop", 32'(bus.frame_avail), 32'(exp_q.size() != 0));
        end
    endtask

    initial begin
        bus.width           = 2'b11;
        bus.trace_valid     = 1'b0;
        bus.trace_data      = 4'b0000;
        bus.frame_word_next = 1'b0;
        bus.frame_next      = 1'b0;
        m_sync = 1'b0;
        m_to   = 0;
        m_ovf  = 0;
        #12;
        chk("rst_sync", 32'(bus.sync), 32'd0);
        chk("rst_avail", 32'(bus.frame_avail), 32'd0);
        chk("rst_ovf", 32'(bus.ovf_count), 32'd0);
        chk("rst_word", 32'(bus.frame_word), 32'd0);
        rst = 1'b1;
        tick();
        tick();

        // Read requests with nothing buffered are ignored
        bus.frame_word_next = 1'b1;
        tick();
        bus.frame_next = 1'b1;
        tick();
        bus.frame_word_next = 1'b0;
        bus.frame_next      = 1'b0;
        chk("avail_empty", 32'(bus.frame_avail), 32'd0);

        // 4-bit stream of bytes 00..0F
        for (int b = 0; b < 16; b++) bytes[b] = 8'(b);
        send_frame(1'b1, 1'b0);
        chk("t1_w0", 32'(bus.frame_word), 32'h0100);
        read_frame();

        // Same stream at 1 and 2 bits per chunk
        set_width(2'b01);
        send_frame(1'b1, 1'b0);
        read_frame();
        set_width(2'b10);
        send_frame(1'b1, 1'b0);
        read_frame();

        // Width change mid-frame loses sync and the partial frame
        set_width(2'b11);
        send_raw(1'b1, 8);
        m_sync = 1'b1;
        m_to   = 0;
        chk("t2_sync_part", 32'(bus.sync), 32'(m_sync));
        set_width(2'b10);
        send_raw(1'b0, 8);
        tick();
        tick();
        chk("t2_avail", 32'(bus.frame_avail), 32'd0);
        chk("t2_sync", 32'(bus.sync), 32'(m_sync));

        // Idle frame of 8 x 0x7FFF
        for (int b = 0; b < 16; b++) bytes[b] = (b % 2 == 0) ? 8'hFF : 8'h7F;
        send_frame(1'b1, 1'b0);

        // Overflow: DEPTH+3 frames unread, then commit with a simultaneous pop while full
        for (int i = 0; i < DEPTH + 3; i++) begin
            set_width(2'($urandom_range(0, 3)));
            rand_bytes();
            send_frame(1'b1, 1'b0);
        end
        chk("t4_ovf", 32'(bus.ovf_count), 32'd3);
        rand_bytes();
        send_frame(1'b1, 1'b1);
        chk("t4_ovf_pop", 32'(bus.ovf_count), 32'd3);
        for (int i = 0; i < DEPTH; i++) read_frame();

        // Sync timeout after TMO frames without a fresh sync
        set_width(2'($urandom_range(0, 3)));
        rand_bytes();
        send_frame(1'b1, 1'b0);
        for (int i = 0; i < TMO - 1; i++) begin
            rand_bytes();
            send_frame(1'b0, 1'b0);
        end
        chk("t5_sync", 32'(bus.sync), 32'd0);
        rand_bytes();
        send_frame(1'b0, 1'b0);
        for (int i = 0; i < TMO; i++) read_frame();
        chk("t5_empty", 32'(bus.frame_avail), 32'd0);

        // Asynchronous reset mid-frame with two frames buffered
        for (int i = 0; i < 2; i++) begin
            rand_bytes();
            send_frame(1'b1, 1'b0);
        end
        rand_bytes();
        send_raw(1'b1, 6);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_sync", 32'(bus.sync), 32'd0);
        chk("t6_avail", 32'(bus.frame_avail), 32'd0);
        chk("t6_ovf", 32'(bus.ovf_count), 32'd0);
        chk("t6_word", 32'(bus.frame_word), 32'd0);
        exp_q.delete();
        m_sync = 1'b0;
        m_to   = 0;
        m_ovf  = 0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        tick();
        rand_bytes();
        send_frame(1'b0, 1'b0);
        rand_bytes();
        send_frame(1'b1, 1'b0);
        read_frame();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
